// File: rtl/rgbw_pwm_core.sv
// rgbw_pwm_core
//   Four-channel (R,G,B,W) PWM generator clocked by the system clock. Rising
//   edges of the prescaled clock act as the count-enable tick. Duty updates are
//   staged in pending registers and moved into the active (shadow) registers
//   only at period boundaries, so a PWM period is never cut short or stretched.
//
// Ports
//   clk           system clock, all logic on rising edge
//   reset         asynchronous active-low reset
//   clk_presc     prescaled clock, sampled as data
//   presc_ready   prescaler release; 0 forces IDLE
//   duty_r/g/b/w  duty requests, captured on load
//   load          one-cycle capture strobe
//   pending       captured update waiting for a period boundary
//   load_ack      pulse when pending duties enter the shadow registers
//   period_start  pulse at every period boundary
//   pwm_r/g/b/w   registered PWM outputs, active high
module rgbw_pwm_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_presc,
   input  logic             presc_ready,
   input  logic [WIDTH-1:0] duty_r,
   input  logic [WIDTH-1:0] duty_g,
   input  logic [WIDTH-1:0] duty_b,
   input  logic [WIDTH-1:0] duty_w,
   input  logic             load,
   output logic             pending,
   output logic             load_ack,
   output logic             period_start,
   output logic             pwm_r,
   output logic             pwm_g,
   output logic             pwm_b,
   output logic             pwm_w
);

   localparam int NUM_CH = 4;
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

   state_t                        state_q;
   logic                          presc_q;
   logic [WIDTH-1:0]              cnt_q;
   logic [NUM_CH-1:0][WIDTH-1:0]  shadow_q, pend_q;
   logic                          pending_q, load_ack_q, period_start_q;
   logic [NUM_CH-1:0]             pwm_q, pwm_d;
   logic [NUM_CH-1:0][WIDTH-1:0]  duty_in;
   logic                          tick, boundary, run_en;

   assign duty_in = {duty_w, duty_b, duty_g, duty_r};
   assign tick    = clk_presc & ~presc_q;

   // A dropped presc_ready wins over a coincident tick: no boundary is taken.
   assign boundary = presc_ready & tick &
                     ((state_q == SYNC) || ((state_q == RUN) && (cnt_q == CNT_MAX)));

   // pwm is forced low on the same edge that leaves RUN for IDLE.
   assign run_en = (state_q == RUN) & presc_ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
      assign pwm_d[i] = run_en & (cnt_q < shadow_q[i]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         presc_q        <= 1'b0;
         cnt_q          <= '0;
         shadow_q       <= '0;
         pend_q         <= '0;
         pending_q      <= 1'b0;
         load_ack_q     <= 1'b0;
         period_start_q <= 1'b0;
         pwm_q          <= '0;
      end else begin
         presc_q        <= clk_presc;
         load_ack_q     <= 1'b0;
         period_start_q <= 1'b0;
         pwm_q          <= pwm_d;

         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (presc_ready) state_q <= SYNC;
            end
            SYNC: begin
               if (!presc_ready) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (tick) begin
                  state_q <= RUN;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (!presc_ready) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (tick) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase

         if (load) begin
            pend_q    <= duty_in;
            pending_q <= 1'b1;
         end

         // On a coincident load the shadow takes the old pending values and
         // the new ones stay pending.
         if (boundary) begin
            period_start_q <= 1'b1;
            if (pending_q) begin
               shadow_q   <= pend_q;
               load_ack_q <= 1'b1;
               if (!load) pending_q <= 1'b0;
            end
         end
      end
   end

   assign pending      = pending_q;
   assign load_ack     = load_ack_q;
   assign period_start = period_start_q;
   assign pwm_r        = pwm_q[0];
   assign pwm_g        = pwm_q[1];
   assign pwm_b        = pwm_q[2];
   assign pwm_w        = pwm_q[3];

endmodule

// File: doc/rgbw_pwm_core.md
Name: rgbw_pwm_core

Overview:
Four-channel (R, G, B, W) PWM generator directly downstream of the clock prescaler. It runs on the system clock. It detects rising edges of the prescaled clock and uses them as a count-enable tick. The prescaler's release signal gates operation. Duty updates are double-buffered and applied only at period boundaries, with an acknowledge pulse, so the LED drivers never see a glitched cycle.

Parameters:
WIDTH, 8, bit width of period counter and duty inputs; period = 2^WIDTH ticks

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
clk_presc  input  1  prescaled clock from prescaler, sampled as data in clk domain
presc_ready  input  1  prescaler release (its reset_out); 1 = prescaler active
duty_r  input  WIDTH  red duty request
duty_g  input  WIDTH  green duty request
duty_b  input  WIDTH  blue duty request
duty_w  input  WIDTH  white duty request
load  input  1  one-cycle strobe; captures all four duty inputs into pending registers
pending  output  1  1 while a captured update awaits a period boundary
load_ack  output  1  one-clk pulse on the edge the pending duties enter the active (shadow) registers
period_start  output  1  one-clk pulse at each period start
pwm_r, pwm_g, pwm_b, pwm_w  output  1 each  PWM outputs, active high

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0
  - cnt=0; shadow and pending duties=0; presc_q=0; state=IDLE
  - takes effect immediately, in any state
- Tick detection:
  - presc_q <= clk_presc every cycle
  - tick = clk_presc & ~presc_q, one clk cycle wide
  - clk_presc toggling every clk gives one tick per 2 clk cycles
- State machine:
  - IDLE: cnt held at 0; pwm_* = 0; period_start = 0. Goes to SYNC when presc_ready=1.
  - SYNC: waits for a tick. On the tick: cnt <= 0, boundary event, then RUN.
  - RUN: on each tick, cnt <= cnt+1, wrapping from 2^WIDTH-1 to 0. A tick while cnt==2^WIDTH-1 is a boundary event.
  - presc_ready=0 in SYNC or RUN: next state IDLE, cnt <= 0, pwm_* <= 0. Pending contents and the pending flag are retained.
- Boundary event (same clk edge):
  - period_start <= 1
  - if pending=1: shadow <= pending duties, load_ack <= 1, pending <= 0
- Load:
  - accepted in any state
  - pending duties <= duty_*, pending <= 1
  - load while pending=1 overwrites the pending values (last load wins); only one load_ack results.
- Simultaneous load and boundary:
  - shadow takes the OLD pending values; load_ack pulses only if pending was 1
  - the new values go to pending; pending ends at 1
- PWM outputs:
  - registered: pwm_x <= (state==RUN) && (cnt < shadow_x)
  - one clk latency after a cnt or shadow change
  - duty 0: never high
  - duty 2^WIDTH-1: high 2^WIDTH-1 ticks, low 1 tick per period
  - duty widths are unsigned; the compare is unsigned
- Without a boundary event, load_ack and period_start stay 0.

Test Plan:
1. Reset low, presc_ready=0, clk_presc toggling every clk -> all outputs 0; pwm stays 0 for 1000 cycles. Reset release with presc_ready=0 -> state stays IDLE.
2. Load duty_r=64, others 0; then presc_ready=1, clk_presc toggling every clk -> on the first tick, period_start and load_ack pulse together and pending falls. pwm_r is high for 128 clk cycles of every 512-cycle period; g/b/w stay 0.
3. Load duty_w=255, duty_g=0 -> pwm_w high 510 clk cycles and low 2 per period; pwm_g never high.
4. Mid-period load changes duty_r 64->200 -> pending=1 at once and pwm_r pattern is unchanged until the wrap. At the wrap, load_ack pulses, pending=0, and pwm_r is high 400 clk cycles per period. Two loads in one period -> only the second value is applied, one load_ack.
5. Load asserted on the exact boundary cycle with pending=1 (values A) and new values B -> A applied with load_ack. Pending stays 1, and B is applied at the next boundary with a second load_ack.
6. presc_ready dropped mid-RUN -> pwm_* = 0 next cycle, cnt = 0. Re-asserting it -> SYNC, then restart with period_start on the first tick. Asserting reset mid-RUN -> all outputs 0 asynchronously, without waiting for a clk edge.
